rxr_parser_classic: RTL and testbench
=====================================

# rxr_parser_classic

Receive-side request parser for the classic (non-AXI) TLP interface. It accepts the inbound TLP stream from the vendor PCIe core, decodes the 3DW/4DW request header into sideband metadata, and forwards payload DWords in place with per-DWord enables. It sits between the core's RX TLP port and the RIFFA RX request consumers, and is the receive counterpart of the TX request path. Inbound traffic cannot be backpressured, so the block has no ready signals.

## Interface
- C_PCI_DATA_WIDTH, 128, TLP beat width; only 128 is supported.
- C_VENDOR, "ALTERA", informational only; no behavioural effect.
- CLK  in  1  block clock
- RST_IN  in  1  synchronous, active-high reset
- RX_TLP  in  128  TLP beat; DW0 at [31:0]
- RX_TLP_VALID  in  1  beat qualifier
- RX_TLP_START_FLAG / RX_TLP_END_FLAG  in  1  first / last beat of a TLP
- RX_TLP_START_OFFSET / RX_TLP_END_OFFSET  in  2  DW index of TLP start / last valid DW
- RXR_DATA  out  128  registered copy of RX_TLP
- RXR_DATA_VALID  out  1  beat carries at least one payload DW
- RXR_DATA_WORD_ENABLE  out  4  bit i set means DW i is payload
- RXR_DATA_START_FLAG / RXR_DATA_END_FLAG  out  1  first / last payload beat
- RXR_DATA_START_OFFSET / RXR_DATA_END_OFFSET  out  2  DW index of first / last payload DW
- RXR_META_VALID  out  1  one-cycle pulse per accepted TLP
- RXR_META_FMT  out  3  DW0[31:29]
- RXR_META_TYPE  out  5  DW0[28:24]
- RXR_META_TC  out  3  DW0[22:20]
- RXR_META_EP  out  1  DW0[14]
- RXR_META_ATTR  out  2  DW0[13:12]
- RXR_META_LENGTH  out  10  DW0[9:0]
- RXR_META_REQUESTER_ID  out  16  DW1[31:16]
- RXR_META_TAG  out  8  DW1[15:8]
- RXR_META_LDWBE / RXR_META_FDWBE  out  4  DW1[7:4] / DW1[3:0]
- RXR_META_ADDR  out  64  3DW: {32'b0, DW2[31:2], 2'b0}; 4DW: {DW2, DW3[31:2], 2'b0}
- RXR_ERR  out  1  one-cycle pulse on malformed or truncated TLP

## Operation
- State machine states:
  - IDLE waits for a start beat.
  - BODY collects beats after the header beat.
  - DROP discards beats until an end beat.
- Header beat: RX_TLP_VALID & START_FLAG. Required START_OFFSET = 0; otherwise pulse RXR_ERR, emit nothing, and go to DROP (or stay in IDLE if END_FLAG is also set).
- A valid header beat latches the meta fields and asserts META_VALID.
- Payload present iff FMT[1] = 1. 4DW header iff FMT[0] = 1.
  - 3DW header with payload: header-beat WE = 4'b1000, DATA_START_OFFSET = 3.
  - 4DW header with payload: the header beat has no payload; payload starts at DW0 of the next beat.
  - No payload: no DATA_VALID for the whole TLP.
- Payload beats: WE has bits set for DWs from the start DW up to END_OFFSET on the end beat; all four bits are set on middle beats.
  - DATA_END_FLAG equals RX END_FLAG on payload TLPs.
  - DATA_END_OFFSET equals RX END_OFFSET.
  - A 4DW header with an END_FLAG header beat and payload is an error.
- DW counter (11 bits) accumulates popcount(WE). Expected count is LENGTH, with LENGTH = 0 meaning 1024. A mismatch at the end beat pulses RXR_ERR; data is still forwarded.
- END_FLAG on the header beat with no further payload returns to IDLE in the same cycle.
- A start beat arriving in BODY truncates the old TLP:
  - pulse RXR_ERR;
  - no end flag is emitted for the old TLP;
  - the new beat is processed as a header beat.
- Beats with RX_TLP_VALID = 0 are ignored in every state. Non-start beats in IDLE are ignored.

## Timing
- All outputs are registered, with latency 1: an input beat at cycle n appears at cycle n+1. META_VALID coincides with the header beat's data output.
- RXR_ERR for a length mismatch is asserted in the same output cycle as DATA_END_FLAG.
- RXR_ERR for a bad start offset or truncation is asserted at n+1 of the offending beat.
- Reset: every valid, flag, WE and ERR output is 0; RXR_DATA and meta fields are 0; state is IDLE; counter is 0.
- Reset mid-packet: remaining beats of that TLP are ignored until the next START_FLAG. No ERR is raised.
- Throughput: one beat per cycle, back-to-back TLPs with no idle cycles required.

## Test plan
- 3DW MWr, LENGTH = 4, addr 0x10000010: beat0 start, beat1 end with END_OFFSET = 2.
  - Cycle 1: META_VALID, ADDR = 0x10000010, WE = 1000, START_OFFSET = 3.
  - Cycle 2: WE = 0111, END_FLAG, END_OFFSET = 2, ERR = 0.
- 4DW MWr, LENGTH = 1, addr 0x1_2345_6780: header beat, then a beat with END_OFFSET = 0.
  - ADDR = 0x0000000123456780.
  - Data beat: WE = 0001, START_FLAG and END_FLAG both set.
- 3DW MRd, single beat, LENGTH = 8, tag 0x5A: META_VALID with TAG = 0x5A and LENGTH = 8; DATA_VALID never asserted.
- 3DW MWr with LENGTH = 4 but only 3 payload DWs: data forwarded; ERR pulses with END_FLAG.
- Start beat mid-BODY: ERR pulse; the new TLP's meta is correct; the old TLP gets no END_FLAG.
- RST_IN asserted after beat0 of a 3-beat TLP: outputs are 0 next cycle. The remaining beats produce nothing. The next TLP parses normally.

Source files
------------

// File: rtl/rxr_parser_classic.sv
// rxr_parser_classic: decodes 3DW/4DW request headers from the classic RX TLP stream into
// sideband metadata and forwards payload DWords in place with per-DWord enables.
module rxr_parser_classic #(
    parameter int    C_PCI_DATA_WIDTH = 128,
    parameter string C_VENDOR         = "ALTERA"
) (
    input  logic                        CLK,
    input  logic                        RST_IN,
    input  logic [C_PCI_DATA_WIDTH-1:0] RX_TLP,
    input  logic                        RX_TLP_VALID,
    input  logic                        RX_TLP_START_FLAG,
    input  logic                        RX_TLP_END_FLAG,
    input  logic [1:0]                  RX_TLP_START_OFFSET,
    input  logic [1:0]                  RX_TLP_END_OFFSET,
    output logic [C_PCI_DATA_WIDTH-1:0] RXR_DATA,
    output logic                        RXR_DATA_VALID,
    output logic [3:0]                  RXR_DATA_WORD_ENABLE,
    output logic                        RXR_DATA_START_FLAG,
    output logic                        RXR_DATA_END_FLAG,
    output logic [1:0]                  RXR_DATA_START_OFFSET,
    output logic [1:0]                  RXR_DATA_END_OFFSET,
    output logic                        RXR_META_VALID,
    output logic [2:0]                  RXR_META_FMT,
    output logic [4:0]                  RXR_META_TYPE,
    output logic [2:0]                  RXR_META_TC,
    output logic                        RXR_META_EP,
    output logic [1:0]                  RXR_META_ATTR,
    output logic [9:0]                  RXR_META_LENGTH,
    output logic [15:0]                 RXR_META_REQUESTER_ID,
    output logic [7:0]                  RXR_META_TAG,
    output logic [3:0]                  RXR_META_LDWBE,
    output logic [3:0]                  RXR_META_FDWBE,
    output logic [63:0]                 RXR_META_ADDR,
    output logic                        RXR_ERR
);
    if (C_PCI_DATA_WIDTH != 128 || C_VENDOR == "") begin : g_bad_cfg
        $error("rxr_parser_classic supports only a 128-bit datapath");
    end

    typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

    state_t      state, state_n;
    logic [10:0] cnt, cnt_n, exp_len, exp_n;
    logic        pay, pay_n, first, first_n;
    logic        dv_n, sf_n, ef_n, mv_n, err_n;
    logic [3:0]  we_n, hi_mask;
    logic [1:0]  so_n, eo_n;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic        hdr;

    assign dw0     = RX_TLP[31:0];
    assign dw1     = RX_TLP[63:32];
    assign dw2     = RX_TLP[95:64];
    assign dw3     = RX_TLP[127:96];
    assign hdr     = RX_TLP_VALID & RX_TLP_START_FLAG & (state != DROP);
    assign hi_mask = 4'b1111 >> (2'd3 - RX_TLP_END_OFFSET);

    function automatic logic [10:0] pop4(input logic [3:0] w);
        return 11'(w[0]) + 11'(w[1]) + 11'(w[2]) + 11'(w[3]);
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        exp_n   = exp_len;
        pay_n   = pay;
        first_n = first;
        dv_n    = 1'b0;
        we_n    = 4'b0;
        sf_n    = 1'b0;
        ef_n    = 1'b0;
        so_n    = 2'd0;
        eo_n    = 2'd0;
        mv_n    = 1'b0;
        err_n   = 1'b0;
        if (hdr) begin
            // A start beat while still in BODY means the previous TLP was truncated.
            err_n = (state == BODY) | (RX_TLP_START_OFFSET != 2'd0);
            if (RX_TLP_START_OFFSET != 2'd0) begin
                state_n = RX_TLP_END_FLAG ? IDLE : DROP;
            end else begin
                mv_n    = 1'b1;
                pay_n   = dw0[30];
                exp_n   = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
                cnt_n   = 11'd0;
                first_n = dw0[30] & dw0[29] & ~RX_TLP_END_FLAG;
                state_n = RX_TLP_END_FLAG ? IDLE : BODY;
                if (dw0[30] & ~dw0[29]) begin
                    we_n  = RX_TLP_END_FLAG ? (4'b1000 & hi_mask) : 4'b1000;
                    dv_n  = |we_n;
                    sf_n  = 1'b1;
                    so_n  = 2'd3;
                    ef_n  = RX_TLP_END_FLAG;
                    eo_n  = RX_TLP_END_OFFSET;
                    cnt_n = pop4(we_n);
                    err_n = err_n | (RX_TLP_END_FLAG & (cnt_n != exp_n));
                end
                err_n = err_n | (dw0[30] & dw0[29] & RX_TLP_END_FLAG);
            end
        end else if (RX_TLP_VALID & (state == BODY)) begin
            if (pay) begin
                we_n    = RX_TLP_END_FLAG ? hi_mask : 4'b1111;
                dv_n    = 1'b1;
                sf_n    = first;
                first_n = 1'b0;
                ef_n    = RX_TLP_END_FLAG;
                eo_n    = RX_TLP_END_OFFSET;
                cnt_n   = cnt + pop4(we_n);
                err_n   = RX_TLP_END_FLAG & (cnt_n != exp_len);
            end
            state_n = RX_TLP_END_FLAG ? IDLE : BODY;
        end else if (RX_TLP_VALID & RX_TLP_END_FLAG & (state == DROP)) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST_IN) begin
            state                 <= IDLE;
            cnt                   <= 11'd0;
            exp_len               <= 11'd0;
            pay                   <= 1'b0;
            first                 <= 1'b0;
            RXR_DATA              <= '0;
            RXR_DATA_VALID        <= 1'b0;
            RXR_DATA_WORD_ENABLE  <= 4'b0;
            RXR_DATA_START_FLAG   <= 1'b0;
            RXR_DATA_END_FLAG     <= 1'b0;
            RXR_DATA_START_OFFSET <= 2'd0;
            RXR_DATA_END_OFFSET   <= 2'd0;
            RXR_META_VALID        <= 1'b0;
            RXR_META_FMT          <= 3'd0;
            RXR_META_TYPE         <= 5'd0;
            RXR_META_TC           <= 3'd0;
            RXR_META_EP           <= 1'b0;
            RXR_META_ATTR         <= 2'd0;
            RXR_META_LENGTH       <= 10'd0;
            RXR_META_REQUESTER_ID <= 16'd0;
            RXR_META_TAG          <= 8'd0;
            RXR_META_LDWBE        <= 4'd0;
            RXR_META_FDWBE        <= 4'd0;
            RXR_META_ADDR         <= 64'd0;
            RXR_ERR               <= 1'b0;
        end else begin
            state                 <= state_n;
            cnt                   <= cnt_n;
            exp_len               <= exp_n;
            pay                   <= pay_n;
            first                 <= first_n;
            RXR_DATA              <= RX_TLP;
            RXR_DATA_VALID        <= dv_n;
            RXR_DATA_WORD_ENABLE  <= we_n;
            RXR_DATA_START_FLAG   <= sf_n;
            RXR_DATA_END_FLAG     <= ef_n;
            RXR_DATA_START_OFFSET <= so_n;
            RXR_DATA_END_OFFSET   <= eo_n;
            RXR_META_VALID        <= mv_n;
            RXR_ERR               <= err_n;
            if (mv_n) begin
                RXR_META_FMT          <= dw0[31:29];
                RXR_META_TYPE         <= dw0[28:24];
                RXR_META_TC           <= dw0[22:20];
                RXR_META_EP           <= dw0[14];
                RXR_META_ATTR         <= dw0[13:12];
                RXR_META_LENGTH       <= dw0[9:0];
                RXR_META_REQUESTER_ID <= dw1[31:16];
                RXR_META_TAG          <= dw1[15:8];
                RXR_META_LDWBE        <= dw1[7:4];
                RXR_META_FDWBE        <= dw1[3:0];
                RXR_META_ADDR         <= dw0[29] ? {dw2, dw3[31:2], 2'b00} : {32'd0, dw2[31:2], 2'b00};
            end
        end
    end
endmodule

// File: tb/tb_rxr_parser_classic.sv
// tb_rxr_parser_classic: directed beats with hand-computed expectations, checked by immediate assertions.
module tb_rxr_parser_classic;
    logic         CLK = 1'b0;
    logic         RST_IN;
    logic [127:0] RX_TLP;
    logic         RX_TLP_VALID, RX_TLP_START_FLAG, RX_TLP_END_FLAG;
    logic [1:0]   RX_TLP_START_OFFSET, RX_TLP_END_OFFSET;
    logic [127:0] RXR_DATA;
    logic         RXR_DATA_VALID, RXR_DATA_START_FLAG, RXR_DATA_END_FLAG;
    logic [3:0]   RXR_DATA_WORD_ENABLE;
    logic [1:0]   RXR_DATA_START_OFFSET, RXR_DATA_END_OFFSET;
    logic         RXR_META_VALID, RXR_META_EP, RXR_ERR;
    logic [2:0]   RXR_META_FMT, RXR_META_TC;
    logic [4:0]   RXR_META_TYPE;
    logic [1:0]   RXR_META_ATTR;
    logic [9:0]   RXR_META_LENGTH;
    logic [15:0]  RXR_META_REQUESTER_ID;
    logic [7:0]   RXR_META_TAG;
    logic [3:0]   RXR_META_LDWBE, RXR_META_FDWBE;
    logic [63:0]  RXR_META_ADDR;

    int n_chk = 0;
    int n_fail = 0;

    rxr_parser_classic dut (
        .CLK(CLK), .RST_IN(RST_IN), .RX_TLP(RX_TLP), .RX_TLP_VALID(RX_TLP_VALID),
        .RX_TLP_START_FLAG(RX_TLP_START_FLAG), .RX_TLP_END_FLAG(RX_TLP_END_FLAG),
        .RX_TLP_START_OFFSET(RX_TLP_START_OFFSET), .RX_TLP_END_OFFSET(RX_TLP_END_OFFSET),
        .RXR_DATA(RXR_DATA), .RXR_DATA_VALID(RXR_DATA_VALID),
        .RXR_DATA_WORD_ENABLE(RXR_DATA_WORD_ENABLE), .RXR_DATA_START_FLAG(RXR_DATA_START_FLAG),
        .RXR_DATA_END_FLAG(RXR_DATA_END_FLAG), .RXR_DATA_START_OFFSET(RXR_DATA_START_OFFSET),
        .RXR_DATA_END_OFFSET(RXR_DATA_END_OFFSET), .RXR_META_VALID(RXR_META_VALID),
        .RXR_META_FMT(RXR_META_FMT), .RXR_META_TYPE(RXR_META_TYPE), .RXR_META_TC(RXR_META_TC),
        .RXR_META_EP(RXR_META_EP), .RXR_META_ATTR(RXR_META_ATTR), .RXR_META_LENGTH(RXR_META_LENGTH),
        .RXR_META_REQUESTER_ID(RXR_META_REQUESTER_ID), .RXR_META_TAG(RXR_META_TAG),
        .RXR_META_LDWBE(RXR_META_LDWBE), .RXR_META_FDWBE(RXR_META_FDWBE),
        .RXR_META_ADDR(RXR_META_ADDR), .RXR_ERR(RXR_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [127:0] d, input logic v, input logic sf, input logic ef,
                        input logic [1:0] so, input logic [1:0] eo);
        RX_TLP = d;
        RX_TLP_VALID = v;
        RX_TLP_START_FLAG = sf;
        RX_TLP_END_FLAG = ef;
        RX_TLP_START_OFFSET = so;
        RX_TLP_END_OFFSET = eo;
        @(posedge CLK);
        #1;
    endtask

    // DW0 with TC=5, EP=1, ATTR=2, type 0
    function automatic logic [31:0] mk_dw0(input logic [2:0] fmt, input logic [9:0] len);
        return {fmt, 5'd0, 1'b0, 3'd5, 4'd0, 1'b0, 1'b1, 2'b10, 2'b00, len};
    endfunction

    initial begin
        RST_IN = 1'b1;
        beat('0, 0, 0, 0, 0, 0);
        beat('0, 0, 0, 0, 0, 0);
        chk("rst_dv", RXR_DATA_VALID, 0);
        chk("rst_mv", RXR_META_VALID, 0);
        chk("rst_err", RXR_ERR, 0);
        chk("rst_we", RXR_DATA_WORD_ENABLE, 0);
        chk("rst_addr", RXR_META_ADDR, 0);
        RST_IN = 1'b0;

        // 3DW MWr, LENGTH 4, addr 0x10000010
        beat({32'hA0A0A0A0, 32'h10000010, 32'h1234_11_FF, mk_dw0(3'b010, 10'd4)}, 1, 1, 0, 0, 0);
        chk("t1_mv", RXR_META_VALID, 1);
        chk("t1_addr", RXR_META_ADDR, 64'h10000010);
        chk("t1_we", RXR_DATA_WORD_ENABLE, 4'b1000);
        chk("t1_so", RXR_DATA_START_OFFSET, 3);
        chk("t1_sf", RXR_DATA_START_FLAG, 1);
        chk("t1_dv", RXR_DATA_VALID, 1);
        chk("t1_fmt", RXR_META_FMT, 3'b010);
        chk("t1_len", RXR_META_LENGTH, 4);
        chk("t1_rid", RXR_META_REQUESTER_ID, 16'h1234);
        chk("t1_tag", RXR_META_TAG, 8'h11);
        chk("t1_tc_ep_attr", {RXR_META_TC, RXR_META_EP, RXR_META_ATTR}, {3'd5, 1'b1, 2'b10});
        chk("t1_be", {RXR_META_LDWBE, RXR_META_FDWBE}, 8'hFF);
        beat({32'h0, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1}, 1, 0, 1, 0, 2);
        chk("t1_we2", RXR_DATA_WORD_ENABLE, 4'b0111);
        chk("t1_ef", RXR_DATA_END_FLAG, 1);
        chk("t1_eo", RXR_DATA_END_OFFSET, 2);
        chk("t1_err", RXR_ERR, 0);
        chk("t1_sf2", RXR_DATA_START_FLAG, 0);
        chk("t1_data", RXR_DATA, {32'h0, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1});

        // 4DW MWr, LENGTH 1, addr 0x1_2345_6780
        beat({32'h23456780, 32'h00000001, 32'h5678_22_0F, mk_dw0(3'b011, 10'd1)}, 1, 1, 0, 0, 0);
        chk("t2_addr", RXR_META_ADDR, 64'h0000000123456780);
        chk("t2_dv", RXR_DATA_VALID, 0);
        chk("t2_mv", RXR_META_VALID, 1);
        beat({96'h0, 32'hBEEFBEEF}, 1, 0, 1, 0, 0);
        chk("t2_we", RXR_DATA_WORD_ENABLE, 4'b0001);
        chk("t2_flags", {RXR_DATA_VALID, RXR_DATA_START_FLAG, RXR_DATA_END_FLAG}, 3'b111);
        chk("t2_err", RXR_ERR, 0);

        // 3DW MRd single beat, LENGTH 8, tag 0x5A
        beat({32'h0, 32'h00002000, 32'h0001_5A_FF, mk_dw0(3'b000, 10'd8)}, 1, 1, 1, 0, 2);
        chk("t3_mv", RXR_META_VALID, 1);
        chk("t3_tag", RXR_META_TAG, 8'h5A);
        chk("t3_len", RXR_META_LENGTH, 8);
        chk("t3_dv", RXR_DATA_VALID, 0);
        beat('0, 0, 0, 0, 0, 0);
        chk("t3_dv_idle", RXR_DATA_VALID, 0);
        chk("t3_mv_idle", RXR_META_VALID, 0);

        // 3DW MWr LENGTH 4 carrying only 3 DWs
        beat({32'hC0C0C0C0, 32'h00003000, 32'h0002_01_FF, mk_dw0(3'b010, 10'd4)}, 1, 1, 0, 0, 0);
        beat({64'h0, 32'hC2C2C2C2, 32'hC1C1C1C1}, 1, 0, 1, 0, 1);
        chk("t4_we", RXR_DATA_WORD_ENABLE, 4'b0011);
        chk("t4_dv_ef", {RXR_DATA_VALID, RXR_DATA_END_FLAG}, 2'b11);
        chk("t4_err", RXR_ERR, 1);
        beat('0, 0, 0, 0, 0, 0);
        chk("t4_err_clr", RXR_ERR, 0);

        // start beat while in BODY truncates the old TLP
        beat({32'hD0D0D0D0, 32'h00004000, 32'h0003_02_FF, mk_dw0(3'b010, 10'd8)}, 1, 1, 0, 0, 0);
        beat({32'hD4, 32'hD3, 32'hD2, 32'hD1}, 1, 0, 0, 0, 3);
        chk("t5_mid_we", RXR_DATA_WORD_ENABLE, 4'b1111);
        chk("t5_mid_ef", RXR_DATA_END_FLAG, 0);
        beat({32'h0, 32'h00005000, 32'hABCD_77_0F, mk_dw0(3'b000, 10'd1)}, 1, 1, 1, 0, 2);
        chk("t5_err", RXR_ERR, 1);
        chk("t5_mv", RXR_META_VALID, 1);
        chk("t5_tag", RXR_META_TAG, 8'h77);
        chk("t5_rid", RXR_META_REQUESTER_ID, 16'hABCD);
        chk("t5_addr", RXR_META_ADDR, 64'h5000);
        chk("t5_ef", RXR_DATA_END_FLAG, 0);
        chk("t5_dv", RXR_DATA_VALID, 0);

        // reset in the middle of a 3-beat TLP
        beat({32'hE0E0E0E0, 32'h00006000, 32'h0004_03_FF, mk_dw0(3'b010, 10'd9)}, 1, 1, 0, 0, 0);
        chk("t6_mv", RXR_META_VALID, 1);
        RST_IN = 1'b1;
        beat({32'hE4, 32'hE3, 32'hE2, 32'hE1}, 1, 0, 0, 0, 3);
        RST_IN = 1'b0;
        chk("t6_rst_outs", {RXR_DATA_VALID, RXR_META_VALID, RXR_ERR, RXR_DATA_WORD_ENABLE}, 7'b0);
        chk("t6_rst_data", RXR_DATA, 0);
        chk("t6_rst_addr", RXR_META_ADDR, 0);
        beat({32'hE8, 32'hE7, 32'hE6, 32'hE5}, 1, 0, 1, 0, 3);
        chk("t6_tail", {RXR_DATA_VALID, RXR_DATA_END_FLAG, RXR_ERR, RXR_META_VALID}, 4'b0);
        beat({32'h0, 32'h00007000, 32'h0005_33_FF, mk_dw0(3'b000, 10'd2)}, 1, 1, 1, 0, 2);
        chk("t6_next_mv", RXR_META_VALID, 1);
        chk("t6_next_tag", RXR_META_TAG, 8'h33);
        chk("t6_next_err", RXR_ERR, 0);

        // bad start offset: error, no meta, drop until the end beat
        beat({32'h0, 32'h00008000, 32'h0006_44_FF, mk_dw0(3'b010, 10'd4)}, 1, 1, 0, 1, 0);
        chk("t7_err", RXR_ERR, 1);
        chk("t7_mv", {RXR_META_VALID, RXR_DATA_VALID}, 2'b00);
        chk("t7_tag_held", RXR_META_TAG, 8'h33);
        beat({32'hF4, 32'hF3, 32'hF2, 32'hF1}, 1, 0, 1, 0, 3);
        chk("t7_drop", {RXR_DATA_VALID, RXR_ERR, RXR_DATA_END_FLAG}, 3'b000);

        // 4DW write whose header beat also ends the TLP is malformed
        beat({32'h00009000, 32'h0, 32'h0007_55_FF, mk_dw0(3'b011, 10'd1)}, 1, 1, 1, 0, 3);
        chk("t8_err", RXR_ERR, 1);
        chk("t8_dv", RXR_DATA_VALID, 0);

        // LENGTH 0 means 1024 DWs: one DW delivered must flag a mismatch
        beat({32'h11111111, 32'h0000A000, 32'h0008_66_FF, mk_dw0(3'b010, 10'd0)}, 1, 1, 1, 0, 3);
        chk("t9_we", RXR_DATA_WORD_ENABLE, 4'b1000);
        chk("t9_err", RXR_ERR, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
